// File: rtl/aquila_mem_initiator.sv
// Requester-side driver for the Aquila code/data memory interface.
// Runs one harness command at a time and returns data, timeout or error.
module aquila_mem_initiator #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [2:0]          cmd_type_i,
    input  logic [XLEN-1:0]     cmd_addr_i,
    input  logic [XLEN-1:0]     cmd_wdata_i,
    input  logic [XLEN/8-1:0]   cmd_be_i,
    input  logic [4:0]          cmd_amo_type_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [XLEN-1:0]     rsp_data_o,
    output logic                rsp_timeout_o,
    output logic                rsp_error_o,
    output logic [XLEN-1:0]     code_addr_o,
    output logic                code_req_o,
    input  logic [XLEN-1:0]     code_i,
    input  logic                code_ready_i,
    output logic [XLEN-1:0]     data_addr_o,
    output logic [XLEN-1:0]     data_o,
    output logic                data_rw_o,
    output logic [XLEN/8-1:0]   data_byte_enable_o,
    output logic                data_req_o,
    output logic                data_is_amo_o,
    output logic [4:0]          data_amo_type_o,
    output logic                cache_flush_o,
    input  logic [XLEN-1:0]     data_i,
    input  logic                data_ready_i,
    output logic [CNT_W-1:0]    fetch_cnt_o,
    output logic [CNT_W-1:0]    load_cnt_o,
    output logic [CNT_W-1:0]    store_cnt_o,
    output logic [CNT_W-1:0]    timeout_cnt_o
);

    localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] T_FETCH = 3'd0;
    localparam logic [2:0] T_LOAD  = 3'd1;
    localparam logic [2:0] T_STORE = 3'd2;
    localparam logic [2:0] T_AMO   = 3'd3;
    localparam logic [2:0] T_FLUSH = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state, state_nx;
    logic [2:0]      typ_q;
    logic [WC_W-1:0] wcnt;
    logic            bad_cmd;
    logic            is_read;
    logic            is_data;
    logic            ready_hit;
    logic            expired;
    logic            accept;
    logic            rsp_done;

    assign bad_cmd = (cmd_type_i > T_FLUSH) ||
                     (cmd_type_i == T_FETCH && cmd_addr_i[1:0] != 2'b00);
    assign is_data = (cmd_type_i == T_LOAD) || (cmd_type_i == T_STORE) ||
                     (cmd_type_i == T_AMO);
    assign is_read = (typ_q == T_FETCH) || (typ_q == T_LOAD) ||
                     (typ_q == T_AMO);
    assign ready_hit = (typ_q == T_FETCH) ? code_ready_i : data_ready_i;
    assign expired   = (wcnt == WC_W'(TIMEOUT_CYCLES));
    assign accept    = (state == S_IDLE) && cmd_valid_i;
    assign rsp_done  = (state == S_RESP) && rsp_ready_i;

    assign cmd_ready_o   = (state == S_IDLE);
    assign rsp_valid_o   = (state == S_RESP);
    assign code_req_o    = (state == S_ISSUE) && (typ_q == T_FETCH);
    assign data_req_o    = (state == S_ISSUE) &&
                           (typ_q == T_LOAD || typ_q == T_STORE ||
                            typ_q == T_AMO);
    assign cache_flush_o = (state == S_ISSUE) && (typ_q == T_FLUSH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:  if (cmd_valid_i) state_nx = bad_cmd ? S_RESP : S_ISSUE;
            S_ISSUE: state_nx = is_read ? S_WAIT : S_RESP;
            S_WAIT:  if (ready_hit || expired) state_nx = S_RESP;
            S_RESP:  if (rsp_ready_i) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus fields are loaded at accept and held through WAIT and beyond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            typ_q              <= '0;
            code_addr_o        <= '0;
            data_addr_o        <= '0;
            data_o             <= '0;
            data_rw_o          <= 1'b0;
            data_byte_enable_o <= '0;
            data_is_amo_o      <= 1'b0;
            data_amo_type_o    <= '0;
        end else if (accept) begin
            typ_q <= cmd_type_i;
            if (!bad_cmd && cmd_type_i == T_FETCH) begin
                code_addr_o <= cmd_addr_i;
            end
            if (!bad_cmd && is_data) begin
                data_addr_o        <= cmd_addr_i;
                data_rw_o          <= (cmd_type_i != T_LOAD);
                data_o             <= (cmd_type_i != T_LOAD) ? cmd_wdata_i : '0;
                data_byte_enable_o <= cmd_be_i;
                data_is_amo_o      <= (cmd_type_i == T_AMO);
                data_amo_type_o    <= (cmd_type_i == T_AMO) ? cmd_amo_type_i : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt          <= '0;
            rsp_data_o    <= '0;
            rsp_timeout_o <= 1'b0;
            rsp_error_o   <= 1'b0;
        end else begin
            if (accept && bad_cmd) begin
                rsp_error_o <= 1'b1;
                rsp_data_o  <= '0;
            end
            if (state == S_ISSUE) begin
                wcnt <= WC_W'(1);
            end
            if (state == S_WAIT) begin
                if (ready_hit) begin
                    rsp_data_o <= (typ_q == T_FETCH) ? code_i : data_i;
                end else if (expired) begin
                    rsp_timeout_o <= 1'b1;
                    rsp_data_o    <= '0;
                end else begin
                    wcnt <= wcnt + WC_W'(1);
                end
            end
            if (rsp_done) begin
                rsp_data_o    <= '0;
                rsp_timeout_o <= 1'b0;
                rsp_error_o   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_o   <= '0;
            load_cnt_o    <= '0;
            store_cnt_o   <= '0;
            timeout_cnt_o <= '0;
        end else if (rsp_done && !rsp_error_o) begin
            if (rsp_timeout_o) begin
                timeout_cnt_o <= timeout_cnt_o + CNT_W'(1);
            end else if (typ_q == T_FETCH) begin
                fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
            end else if (typ_q == T_LOAD) begin
                load_cnt_o <= load_cnt_o + CNT_W'(1);
            end else if (typ_q == T_STORE) begin
                store_cnt_o <= store_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aquila_mem_initiator.sv
// Bench for aquila_mem_initiator: directed plan steps plus random commands
// checked against a latency/response model derived from command rules.
module tb_aquila_mem_initiator;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_type_i = '0;
    logic [31:0] cmd_addr_i = '0;
    logic [31:0] cmd_wdata_i = '0;
    logic [3:0]  cmd_be_i = '0;
    logic [4:0]  cmd_amo_type_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        rsp_error_o;
    logic [31:0] code_addr_o;
    logic        code_req_o;
    logic [31:0] code_i = '0;
    logic        code_ready_i = 1'b0;
    logic [31:0] data_addr_o;
    logic [31:0] data_o;
    logic        data_rw_o;
    logic [3:0]  data_byte_enable_o;
    logic        data_req_o;
    logic        data_is_amo_o;
    logic [4:0]  data_amo_type_o;
    logic        cache_flush_o;
    logic [31:0] data_i = '0;
    logic        data_ready_i = 1'b0;
    logic [15:0] fetch_cnt_o, load_cnt_o, store_cnt_o, timeout_cnt_o;

    int checks = 0;
    int failures = 0;
    int exp_fetch = 0, exp_load = 0, exp_store = 0, exp_to = 0;

    aquila_mem_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_type_i(cmd_type_i), .cmd_addr_i(cmd_addr_i),
        .cmd_wdata_i(cmd_wdata_i), .cmd_be_i(cmd_be_i),
        .cmd_amo_type_i(cmd_amo_type_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o),
        .rsp_error_o(rsp_error_o),
        .code_addr_o(code_addr_o), .code_req_o(code_req_o),
        .code_i(code_i), .code_ready_i(code_ready_i),
        .data_addr_o(data_addr_o), .data_o(data_o), .data_rw_o(data_rw_o),
        .data_byte_enable_o(data_byte_enable_o), .data_req_o(data_req_o),
        .data_is_amo_o(data_is_amo_o), .data_amo_type_o(data_amo_type_o),
        .cache_flush_o(cache_flush_o), .data_i(data_i),
        .data_ready_i(data_ready_i),
        .fetch_cnt_o(fetch_cnt_o), .load_cnt_o(load_cnt_o),
        .store_cnt_o(store_cnt_o), .timeout_cnt_o(timeout_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_fetch_cnt"}, 64'(fetch_cnt_o), 64'(16'(exp_fetch)));
        chk({tag, "_load_cnt"}, 64'(load_cnt_o), 64'(16'(exp_load)));
        chk({tag, "_store_cnt"}, 64'(store_cnt_o), 64'(16'(exp_store)));
        chk({tag, "_timeout_cnt"}, 64'(timeout_cnt_o), 64'(16'(exp_to)));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
        chk({tag, "_rsp"}, {rsp_valid_o, rsp_timeout_o, rsp_error_o,
                            rsp_data_o}, 64'd0);
        chk({tag, "_code"}, {code_req_o, code_addr_o}, 64'd0);
        chk({tag, "_daddr"}, {data_req_o, data_addr_o}, 64'd0);
        chk({tag, "_dctl"}, {data_o, data_rw_o, data_byte_enable_o,
                             data_is_amo_o, data_amo_type_o,
                             cache_flush_o}, 64'd0);
        chk_counters(tag);
    endtask

    // d: WAIT cycle (1-based) on which ready is raised for one cycle.
    // hold: ready held high throughout instead.
    task automatic run(input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [4:0] amo, input logic [31:0] rd,
                       input int d, input bit hold, input int stall);
        bit err, rd_type, hit, to, seen;
        int exp_lat, lat;
        logic [31:0] exp_data;
        int nc, nd, nf, pc, pd, pf;
        logic [31:0] ca, da, dw;
        logic [3:0] dbe;
        logic [4:0] damt;
        logic drw, damo;

        err = (t > 3'd4) || (t == 3'd0 && a[1:0] != 2'b00);
        rd_type = (t == 3'd0 || t == 3'd1 || t == 3'd3);
        hit = hold || (d <= TO);
        to = !err && rd_type && !hit;
        if (err) exp_lat = 1;
        else if (!rd_type) exp_lat = 2;
        else if (!hit) exp_lat = TO + 2;
        else exp_lat = (hold ? 1 : d) + 2;
        exp_data = (!err && rd_type && hit) ? rd : 32'd0;

        @(negedge clk);
        chk("cmd_ready_before", 64'(cmd_ready_o), 64'd1);
        code_i = (t == 3'd0) ? rd : $urandom;
        data_i = (t == 3'd0) ? $urandom : rd;
        code_ready_i = hold && t == 3'd0;
        data_ready_i = hold && t != 3'd0;
        cmd_type_i = t; cmd_addr_i = a; cmd_wdata_i = wd;
        cmd_be_i = be; cmd_amo_type_i = amo; cmd_valid_i = 1'b1;

        nc = 0; nd = 0; nf = 0; pc = 0; pd = 0; pf = 0;
        ca = '0; da = '0; dw = '0; dbe = '0; damt = '0; drw = 0; damo = 0;
        seen = 0; lat = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                cmd_valid_i = 1'b0;
                cmd_type_i = $urandom;
                cmd_addr_i = $urandom;
            end
            if (code_req_o) begin nc++; pc = n; ca = code_addr_o; end
            if (data_req_o) begin
                nd++; pd = n; da = data_addr_o; dw = data_o;
                drw = data_rw_o; dbe = data_byte_enable_o;
                damo = data_is_amo_o; damt = data_amo_type_o;
            end
            if (cache_flush_o) begin nf++; pf = n; end
            if (rsp_valid_o) begin seen = 1; lat = n; end
            code_ready_i = (t == 3'd0) && (hold || (n >= 2 && n - 1 == d));
            data_ready_i = (t != 3'd0) && (hold || (n >= 2 && n - 1 == d));
        end
        if (!hold) begin code_ready_i = 0; data_ready_i = 0; end

        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_data", 64'(rsp_data_o), 64'(exp_data));
        chk("rsp_flags", {rsp_timeout_o, rsp_error_o}, {to, err});
        chk("code_pulses", 64'(nc), 64'((!err && t == 3'd0) ? 1 : 0));
        chk("data_pulses", 64'(nd),
            64'((!err && (t == 3'd1 || t == 3'd2 || t == 3'd3)) ? 1 : 0));
        chk("flush_pulses", 64'(nf), 64'((!err && t == 3'd4) ? 1 : 0));
        if (nc == 1) begin
            chk("code_req_cycle", 64'(pc), 64'd1);
            chk("code_addr", 64'(ca), 64'(a));
        end
        if (nf == 1) chk("flush_cycle", 64'(pf), 64'd1);
        if (nd == 1) begin
            chk("data_req_cycle", 64'(pd), 64'd1);
            chk("data_addr", 64'(da), 64'(a));
            chk("data_addr_held", 64'(data_addr_o), 64'(a));
            chk("data_rw", 64'(drw), 64'(t != 3'd1));
            if (t != 3'd1) begin
                chk("data_wdata", 64'(dw), 64'(wd));
                chk("data_be", 64'(dbe), 64'(be));
                chk("data_amo", {damo, damt},
                    {t == 3'd3, (t == 3'd3) ? amo : 5'd0});
            end
        end

        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_data", 64'(rsp_data_o), 64'(exp_data));
            chk("stall_flags", {rsp_valid_o, rsp_timeout_o, rsp_error_o},
                {1'b1, to, err});
        end
        rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready_i = 1'b0;
        if (!err) begin
            if (to) exp_to++;
            else if (t == 3'd0) exp_fetch++;
            else if (t == 3'd1) exp_load++;
            else if (t == 3'd2) exp_store++;
        end
        chk("after_hs", {rsp_valid_o, cmd_ready_o}, 64'b01);
        chk_counters("after_hs");
    endtask

    initial begin
        bit any;
        logic [2:0] t;
        logic [31:0] a;

        #12;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run(3'd1, 32'h100, 32'h0, 4'hF, 5'd0, 32'hDEADBEEF, 1, 0, 0);
        run(3'd2, 32'h40, 32'h12345678, 4'hF, 5'd0, 32'h0, 99, 0, 0);
        run(3'd0, 32'h0, 32'h0, 4'h0, 5'd0, 32'h00000013, 1, 1, 0);
        run(3'd0, 32'h4, 32'h0, 4'h0, 5'd0, 32'h00A00093, 1, 1, 0);
        code_ready_i = 1'b0;
        run(3'd1, 32'h180, 32'h0, 4'hF, 5'd0, 32'hCAFEF00D, 99, 0, 0);
        run(3'd1, 32'h184, 32'h0, 4'hF, 5'd0, 32'h0BADBEEF, TO, 0, 0);
        run(3'd0, 32'h102, 32'h0, 4'h0, 5'd0, 32'h11111111, 1, 0, 0);
        run(3'd6, 32'h200, 32'h55, 4'hF, 5'd0, 32'h22222222, 1, 0, 0);
        run(3'd3, 32'h300, 32'hA5A5A5A5, 4'hF, 5'd2, 32'h77, 3, 0, 0);
        run(3'd4, 32'h0, 32'h0, 4'h0, 5'd0, 32'h0, 99, 0, 0);
        run(3'd1, 32'h104, 32'h0, 4'hF, 5'd0, 32'h13572468, 2, 0, 5);

        // Reset asserted while a LOAD sits in WAIT.
        @(negedge clk);
        data_ready_i = 1'b0;
        cmd_type_i = 3'd1; cmd_addr_i = 32'h200; cmd_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_fetch = 0; exp_load = 0; exp_store = 0; exp_to = 0;
        chk_quiet("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        any = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid_o) any = 1;
        end
        chk("no_rsp_after_reset", 64'(any), 64'd0);
        chk("idle_after_reset", 64'(cmd_ready_o), 64'd1);

        for (int i = 0; i < 40; i++) begin
            t = 3'($urandom_range(0, 5));
            if (t == 3'd5) t = 3'($urandom_range(5, 7));
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom);
            run(t, a, $urandom, 4'($urandom), 5'($urandom), $urandom,
                $urandom_range(1, 20), ($urandom_range(0, 5) == 0),
                $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
